// File: rtl/nibble_addsub_pkg.sv
// Shared constants, state type and index-width helper for the nibble add/sub sequencer.
package nibble_addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bits needed to index n nibbles; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = 1; v < n; v = v << 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_addsub_unit.sv
// Combinational 4-bit add/sub stage; carry-in is separate from mode so stages chain
// through the sequencer's carry flop.
module nibble_addsub_unit
  import nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                mode,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  output logic                c_msb
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W:0]   full;
  logic [NIBBLE_W-1:0] low;

  always_comb begin
    b_eff = b ^ {NIBBLE_W{mode}};
    full  = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, c_in};
    // Sum of the bits below the MSB; its top bit is the carry into the MSB.
    low   = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b_eff[NIBBLE_W-2:0]}
          + {{(NIBBLE_W-1){1'b0}}, c_in};
    sum   = full[NIBBLE_W-1:0];
    c_out = full[NIBBLE_W];
    c_msb = low[NIBBLE_W-1];
  end

endmodule

// File: rtl/nibble_addsub_seq.sv
// Multi-nibble add/subtract sequencer: one nibble per clock, LSB first, carry held in a flop.
// Optional signed-overflow flag enabled by defining NIBBLE_ADDSUB_SEQ_OVF_EN.
module nibble_addsub_seq
  import nibble_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] i_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] i_b,
  input  logic                        i_mode,
  output logic [NIBBLE_W*NIBBLES-1:0] o_result,
  output logic                        o_carry,
  output logic                        o_ovf,
  output logic                        o_done
);

  localparam int unsigned W        = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W    = clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        result_q;
  logic                mode_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;

  logic [NIBBLE_W-1:0] st_sum;
  logic                st_c_out;
  logic                st_c_msb;

  nibble_addsub_unit u_stage (
    .a     (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b     (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .mode  (mode_q),
    .c_in  (carry_q),
    .sum   (st_sum),
    .c_out (st_c_out),
    .c_msb (st_c_msb)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      o_ready  <= 1'b1;
      o_carry  <= 1'b0;
      o_done   <= 1'b0;
`ifdef NIBBLE_ADDSUB_SEQ_OVF_EN
      o_ovf    <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            a_q     <= i_a;
            b_q     <= i_b;
            mode_q  <= i_mode;
            carry_q <= i_mode;
            idx_q   <= '0;
            o_ready <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*NIBBLE_W +: NIBBLE_W] <= st_sum;
          carry_q <= st_c_out;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state <= DONE;
`ifdef NIBBLE_ADDSUB_SEQ_OVF_EN
            o_ovf <= st_c_msb ^ st_c_out;
`endif
          end
        end
        DONE: begin
          o_done  <= 1'b1;
          o_carry <= carry_q;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef NIBBLE_ADDSUB_SEQ_OVF_EN
  logic ovf_unused;
  assign ovf_unused = st_c_msb;
  assign o_ovf      = 1'b0;
`endif

  assign o_result = result_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Self-checking bench for nibble_addsub_seq (NIBBLES=4); overflow expectations follow
// NIBBLE_ADDSUB_SEQ_OVF_EN when it is defined for the build.
module tb_nibble_addsub_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_mode;
  logic [W-1:0] o_result;
  logic         o_carry;
  logic         o_ovf;
  logic         o_done;

  int checks = 0;
  int errors = 0;

`ifdef NIBBLE_ADDSUB_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  nibble_addsub_seq #(.NIBBLES(N)) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_mode    (i_mode),
    .o_result  (o_result),
    .o_carry   (o_carry),
    .o_ovf     (o_ovf),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain W+1 bit add / two's-complement subtract, signed overflow
  // from operand and result signs.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic m);
    logic [W:0] full;
    logic       v;
    if (m) full = {1'b0, a} - {1'b0, b} + (W+1)'(1 << W);
    else   full = {1'b0, a} + {1'b0, b};
    if (m) v = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {v & OVF_ON, full};
  endfunction

  // Model: accept happens on the edge after a cycle with i_valid while idle; o_done is
  // launched N+1 edges after the accept edge.
  int           cyc = 0;
  int           done_cyc = 0;
  logic         busy = 1'b0;
  logic [W-1:0] exp_res = '0, pend_res = '0;
  logic         exp_c = 1'b0, pend_c = 1'b0;
  logic         exp_v = 1'b0, pend_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic         exp_ready;
    logic         exp_done;
    logic [W+1:0] r;
    if (!i_reset_n) begin
      busy    = 1'b0;
      exp_res = '0;
      exp_c   = 1'b0;
      exp_v   = 1'b0;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_result", 32'(o_result), 32'd0);
      check("rst_carry_ovf", {30'd0, o_carry, o_ovf}, 32'd0);
    end else begin
      exp_ready = !busy || (cyc == done_cyc);
      exp_done  = busy && (cyc == done_cyc);
      if (exp_done) begin
        exp_res = pend_res;
        exp_c   = pend_c;
        exp_v   = pend_v;
      end
      check("m_ready", 32'(o_ready), 32'(exp_ready));
      check("m_done", 32'(o_done), 32'(exp_done));
      if (exp_ready) begin
        check("m_result", 32'(o_result), 32'(exp_res));
        check("m_carry", 32'(o_carry), 32'(exp_c));
        check("m_ovf", 32'(o_ovf), 32'(exp_v));
      end
      if (exp_done) busy = 1'b0;
      if (!busy && i_valid) begin
        r        = ref_op(i_a, i_b, i_mode);
        pend_res = r[W-1:0];
        pend_c   = r[W];
        pend_v   = r[W+1];
        busy     = 1'b1;
        done_cyc = cyc + 1 + N + 1;
      end
    end
  end

  // Waits for o_done after an accept edge; latency counts the edge that captures o_done.
  task automatic wait_done(input string name, output int lat);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
    check({name, "_latency"}, 32'(lat), 32'(N + 2));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic [W-1:0] er, input logic ec,
                        input logic ev);
    int lat;
    @(posedge clk); #1;
    i_valid = 1'b1; i_a = a; i_b = b; i_mode = m;
    @(posedge clk); #1;
    // Operands change during RUN and must not be picked up.
    i_valid = 1'b0; i_a = ~a; i_b = ~b; i_mode = ~m;
    wait_done(name, lat);
    check({name, "_result"}, 32'(o_result), 32'(er));
    check({name, "_carry"}, 32'(o_carry), 32'(ec));
    check({name, "_ovf"}, 32'(o_ovf), 32'(ev));
  endtask

  initial begin
    int lat;
    i_reset_n = 1'b1;
    i_valid   = 1'b0;
    i_a       = '0;
    i_b       = '0;
    i_mode    = 1'b0;
    #2 i_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset_n = 1'b1;
    check("init_ready", 32'(o_ready), 32'd1);
    check("init_result", 32'(o_result), 32'd0);

    // Reset two cycles into an operation: partial result must be wiped, no o_done.
    @(posedge clk); #1;
    i_valid = 1'b1; i_a = 16'h1234; i_b = 16'h0FFF; i_mode = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("partial_result", 32'(o_result), 32'h0033);
    i_reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_result", 32'(o_result), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b1;
    repeat (8) @(posedge clk);

    run_op("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_nb",   16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    run_op("sub_brw",  16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
    repeat (3) @(posedge clk);

    // Back-to-back with i_valid held: second operands appear during RUN.
    @(posedge clk); #1;
    i_valid = 1'b1; i_a = 16'h0003; i_b = 16'h0004; i_mode = 1'b0;
    @(posedge clk); #1;
    i_a = 16'h1111; i_b = 16'h0F0F; i_mode = 1'b1;
    wait_done("b2b_first", lat);
    check("b2b_first_result", 32'(o_result), 32'h0007);
    check("b2b_first_carry", 32'(o_carry), 32'd0);
    @(posedge clk); #1;
    check("b2b_second_accept", 32'(o_ready), 32'd0);
    check("b2b_held_result", 32'(o_result), 32'h0007);
    i_valid = 1'b0;
    wait_done("b2b_second", lat);
    check("b2b_second_result", 32'(o_result), 32'h0202);
    check("b2b_second_carry", 32'(o_carry), 32'd1);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_addsub_seq.md
# nibble_addsub_seq

Multi-nibble add/subtract sequencer. It computes a NIBBLES×4-bit sum or difference by reusing one 4-bit add/sub stage, one nibble per clock, LSB first, with the carry held in a flop between cycles. It sits between the operand-entry logic and the BCD/FND display path, trading latency for area so that wide operands share a single nibble datapath.

## Interface
- NIBBLES, default 4: operand width in nibbles; data width W = 4×NIBBLES; legal range 2–8.
- i_clk  input  1  rising-edge clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operation request; qualifies i_a, i_b, i_mode.
- o_ready  output  1  high only in IDLE; request accepted when i_valid && o_ready.
- i_a  input  W  minuend or addend.
- i_b  input  W  subtrahend or addend.
- i_mode  input  1  0 = add (a+b), 1 = subtract (a−b, two's complement).
- o_result  output  W  registered result.
- o_carry  output  1  final carry-out; in subtract mode 1 = no borrow (a ≥ b unsigned).
- o_ovf  output  1  signed overflow flag (see Configuration).
- o_done  output  1  one-cycle pulse: o_result, o_carry, o_ovf are valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: o_ready=1. On accept, latch a, b, mode; set nibble index idx=0 and carry flop = i_mode; go to RUN.
- RUN: the stage computes a[idx] + (b[idx] ^ {4{mode}}) + carry. The 4-bit sum is written to result nibble idx, the carry flop takes the stage carry-out, and idx increments. When idx = NIBBLES−1 is processed, go to DONE.
- DONE: o_done=1 for exactly one cycle; o_carry = final carry flop. Then go to IDLE.
- Result nibbles are written in place, so o_result is partial during RUN. It holds the final value from DONE until the next accept.
- i_valid outside IDLE is ignored; operands are not re-sampled mid-operation.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Reset (async assert, sync-released by the system):
  - state = IDLE, o_ready = 1.
  - o_result = 0, o_carry = 0, o_ovf = 0, o_done = 0.
  - idx = 0, carry flop = 0.
- Reset mid-RUN aborts the operation with no o_done and returns all outputs to reset values.
- Latency: accept at edge k → RUN occupies edges k+1 … k+NIBBLES → o_done is high in the cycle after edge k+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. With i_valid held high, the next request is accepted in the first IDLE cycle after DONE.
- The stage is combinational between the operand/carry flops and the result/carry flops. There is no internal pipelining.

## Configuration
- Macro: NIBBLE_ADDSUB_SEQ_OVF_EN.
- Defined: on the last nibble, o_ovf = carry into MSB XOR carry out of MSB. It is registered with o_result and valid with o_done.
- Undefined: the overflow logic is omitted and o_ovf is tied to 0. The port list is unchanged.

## Structure
- Package nibble_addsub_pkg holds:
  - NIBBLE_W = 4;
  - the state enum (IDLE, RUN, DONE);
  - the index width function clog2(NIBBLES).
- Sub-module nibble_addsub_unit is a combinational 4-bit stage:
  - inputs: a, b, mode, carry-in;
  - outputs: sum, carry-out, and carry-into-MSB for the overflow flag.
  - The carry-in is separate from mode so that nibbles can be chained.
- The top level holds the FSM, idx counter, carry flop, operand registers and result register.

## Test plan
All cases use NIBBLES=4.
- Reset mid-RUN: assert i_reset_n low two cycles into an operation → o_done never pulses; o_result=0x0000, o_ready=1 immediately.
- Add: a=0x1234, b=0x0FFF, mode=0 → o_result=0x2233, o_carry=0, o_done exactly 6 cycles after the accept edge.
- Add wrap: a=0xFFFF, b=0x0001, mode=0 → o_result=0x0000, o_carry=1.
- Subtract, borrow cases:
  - a=0x1000, b=0x0001, mode=1 → o_result=0x0FFF, o_carry=1.
  - a=0x0001, b=0x0002, mode=1 → o_result=0xFFFF, o_carry=0.
- Overflow, macro on: a=0x7FFF, b=0x0001, mode=0 → o_result=0x8000, o_ovf=1. Macro off: same stimulus → o_ovf=0.
- Back-to-back: i_valid held high with new operands presented during RUN → those operands are ignored; the second accept occurs in the IDLE cycle after DONE; o_result is stable from DONE until the next accept.
